// File: rtl/ecc_scrub_secded.sv
// rtl/ecc_scrub_secded.sv - background SECDED scrubber for a 13-bit {p, c[3:0], d[7:0]} RAM
// Optional feature macro: SCRUB_AUTO_EN (start a sweep after INTERVAL idle cycles).
module ecc_scrub_secded #(
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int INTERVAL   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [12:0]           mem_rdata,
  output logic                  mem_wr,
  output logic [12:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt,
  output logic [ADDR_WIDTH-1:0] last_err_addr,
  output logic                  irq
);
  typedef enum logic [2:0] {IDLE, REQ, RD, WAIT, CHK, WR, NXT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [12:0]           rdata_q, wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  corr_q, uncorr_q;
  logic [ADDR_WIDTH-1:0] last_err_q;
  logic                  irq_q;
  logic                  sweep_start;

`ifdef SCRUB_AUTO_EN
  localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  logic [IW-1:0] idle_cnt_q;
  logic          auto_fire;

  assign auto_fire   = (state_q == IDLE) && (idle_cnt_q == IW'(INTERVAL - 1));
  assign sweep_start = start || auto_fire;

  always_ff @(posedge clk) begin
    if (rst || (state_q != IDLE) || sweep_start) idle_cnt_q <= '0;
    else                                         idle_cnt_q <= idle_cnt_q + 1'b1;
  end
`else
  logic [31:0] unused_interval;
  assign unused_interval = INTERVAL;
  assign sweep_start     = start;
`endif

  logic [7:0]  d;
  logic [3:0]  c_calc, syn;
  logic        par, clean, correctable, uncorrectable;
  logic [12:0] flip, fixed;

  assign d      = rdata_q[7:0];
  assign c_calc = {d[4] ^ d[5] ^ d[6] ^ d[7],
                   d[1] ^ d[2] ^ d[3] ^ d[7],
                   d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6],
                   d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6]};
  assign syn           = c_calc ^ rdata_q[11:8];
  assign par           = ^rdata_q;
  assign clean         = (syn == 4'd0) && !par;
  assign correctable   = par && (syn <= 4'd12);
  assign uncorrectable = !clean && !correctable;

  // Hamming position -> stored bit; syndrome 0 with odd parity means p itself flipped
  always_comb begin
    flip = '0;
    case (syn)
      4'd0:    flip[12] = 1'b1;
      4'd1:    flip[8]  = 1'b1;
      4'd2:    flip[9]  = 1'b1;
      4'd3:    flip[0]  = 1'b1;
      4'd4:    flip[10] = 1'b1;
      4'd5:    flip[1]  = 1'b1;
      4'd6:    flip[2]  = 1'b1;
      4'd7:    flip[3]  = 1'b1;
      4'd8:    flip[11] = 1'b1;
      4'd9:    flip[4]  = 1'b1;
      4'd10:   flip[5]  = 1'b1;
      4'd11:   flip[6]  = 1'b1;
      4'd12:   flip[7]  = 1'b1;
      default: flip     = '0;
    endcase
  end
  assign fixed = rdata_q ^ flip;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (sweep_start) begin
        addr_d  = '0;
        state_d = REQ;
      end
      REQ:  if (mem_gnt) state_d = RD;
      RD:   state_d = WAIT;
      WAIT: state_d = CHK;
      CHK: begin
        if (correctable) begin
          wdata_d = fixed;
          state_d = WR;
        end else begin
          state_d = NXT;
        end
      end
      WR:   state_d = NXT;
      NXT: begin
        done    = &addr_q;
        addr_d  = addr_q + 1'b1;
        state_d = (&addr_q) ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      corr_q     <= '0;
      uncorr_q   <= '0;
      last_err_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (state_q == WAIT) rdata_q <= mem_rdata;
      if ((state_q == IDLE) && sweep_start) irq_q <= 1'b0;
      if (state_q == CHK) begin
        if (correctable && !(&corr_q)) corr_q <= corr_q + 1'b1;
        if (uncorrectable) begin
          if (!(&uncorr_q)) uncorr_q <= uncorr_q + 1'b1;
          last_err_q <= addr_q;
          irq_q      <= 1'b1;
        end
      end
    end
  end

  assign mem_req       = (state_q == REQ) || (state_q == RD) || (state_q == WAIT) ||
                         (state_q == CHK) || (state_q == WR);
  assign mem_rd        = (state_q == RD);
  assign mem_wr        = (state_q == WR);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign busy          = (state_q != IDLE);
  assign corr_cnt      = corr_q;
  assign uncorr_cnt    = uncorr_q;
  assign last_err_addr = last_err_q;
  assign irq           = irq_q;
endmodule
